// File: rtl/pio_sequencer_if.sv
// Bus bundle for pio_sequencer: the CSR slave port and the master port toward an 8-bit output PIO.
// The slave modport is the sequencer's view; the master modport is the host/bench view.
interface pio_sequencer_if;
  logic [3:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  modport slave (
    input  s_address, s_chipselect, s_write_n, s_writedata,
    output s_readdata,
    output m_address, m_chipselect, m_write_n, m_writedata
  );

  modport master (
    output s_address, s_chipselect, s_write_n, s_writedata,
    input  s_readdata,
    input  m_address, m_chipselect, m_write_n, m_writedata
  );
endinterface

// File: rtl/pio_sequencer.sv
// Plays a CSR-programmed table of up to 8 byte patterns onto an output PIO, one write every PERIOD cycles.
// Optional feature macro: PIO_SEQ_IRQ_EN adds CTRL.IEN and an irq output raised on DONE.
module pio_sequencer #(
  parameter int PERIOD_W = 24
) (
  input  logic clk,
  input  logic reset_n,
`ifdef PIO_SEQ_IRQ_EN
  output logic irq,
`endif
  pio_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

  state_t              state;
  logic [2:0]          index;
  logic                done;
  logic                loop_en;
  logic                ien;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] wait_cnt;
  logic [3:0]          length;
  logic [7:0]          pattern [8];
  logic                m_cs;
  logic                m_wn;
  logic [7:0]          m_data;

  logic                wr;
  logic                start;
  logic                stop;
  logic                done_clr;
  logic                busy;
  logic [PERIOD_W-1:0] eff_period;
  logic [2:0]          last_index;
  logic [2:0]          next_index;
  logic [31:0]         rdata;
  logic                unused_wdata;

  assign wr         = bus.s_chipselect & ~bus.s_write_n;
  assign start      = wr && (bus.s_address == 4'd0) && bus.s_writedata[0];
  assign stop       = wr && (bus.s_address == 4'd0) && bus.s_writedata[2];
  assign done_clr   = wr && (bus.s_address == 4'd1) && bus.s_writedata[1];
  assign busy       = (state != IDLE);
  assign eff_period = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
  assign next_index = index + 3'd1;
  assign unused_wdata = ^bus.s_writedata;

  always_comb begin
    last_index = 3'(length - 4'd1);
    if (length == 4'd0)
      last_index = 3'd0;
    else if (length > 4'd8)
      last_index = 3'd7;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_en <= 1'b0;
      period  <= '0;
      length  <= '0;
      for (int i = 0; i < 8; i++)
        pattern[i] <= '0;
`ifdef PIO_SEQ_IRQ_EN
      ien <= 1'b0;
`endif
    end else if (wr) begin
      case (bus.s_address)
        4'd0: begin
          loop_en <= bus.s_writedata[1];
`ifdef PIO_SEQ_IRQ_EN
          ien <= bus.s_writedata[3];
`endif
        end
        4'd2: period <= bus.s_writedata[PERIOD_W-1:0];
        4'd3: length <= bus.s_writedata[3:0];
        default: begin
          if (bus.s_address[3])
            pattern[bus.s_address[2:0]] <= bus.s_writedata[7:0];
        end
      endcase
    end
  end

`ifndef PIO_SEQ_IRQ_EN
  assign ien = 1'b0;
`endif

  // Master outputs default to idle every cycle and are only raised on the edge that enters WRITE.
  // The DONE set is written after the clear so a coincident set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      index    <= '0;
      done     <= 1'b0;
      wait_cnt <= '0;
      m_cs     <= 1'b0;
      m_wn     <= 1'b1;
      m_data   <= '0;
`ifdef PIO_SEQ_IRQ_EN
      irq      <= 1'b0;
`endif
    end else begin
      if (done_clr)
        done <= 1'b0;
      m_cs   <= 1'b0;
      m_wn   <= 1'b1;
      m_data <= '0;
      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              index  <= '0;
              done   <= 1'b0;
              state  <= WRITE;
              m_cs   <= 1'b1;
              m_wn   <= 1'b0;
              m_data <= pattern[0];
            end
          end
          WRITE: begin
            state    <= WAIT;
            wait_cnt <= eff_period - PERIOD_W'(2);
          end
          WAIT: begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - PERIOD_W'(1);
            end else if (index < last_index) begin
              index  <= next_index;
              state  <= WRITE;
              m_cs   <= 1'b1;
              m_wn   <= 1'b0;
              m_data <= pattern[next_index];
            end else if (loop_en) begin
              index  <= '0;
              state  <= WRITE;
              m_cs   <= 1'b1;
              m_wn   <= 1'b0;
              m_data <= pattern[0];
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef PIO_SEQ_IRQ_EN
      irq <= done & ien;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.s_address)
      4'd0: rdata[3:0] = {ien, 1'b0, loop_en, 1'b0};
      4'd1: rdata[6:0] = {index, 2'b00, done, busy};
      4'd2: rdata[PERIOD_W-1:0] = period;
      4'd3: rdata[3:0] = length;
      default: begin
        if (bus.s_address[3])
          rdata[7:0] = pattern[bus.s_address[2:0]];
      end
    endcase
  end

  assign bus.s_readdata   = rdata;
  assign bus.m_address    = 2'b00;
  assign bus.m_chipselect = m_cs;
  assign bus.m_write_n    = m_wn;
  assign bus.m_writedata  = {24'b0, m_data};

endmodule

// File: tb/tb_pio_sequencer.sv
// Directed bench for pio_sequencer: expected strobes (data and cycle) go into a scoreboard queue at START
// and are popped by a bus monitor; CSR readbacks are checked inline.
module tb_pio_sequencer;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset_n;
`ifdef PIO_SEQ_IRQ_EN
  logic irq;
`endif

  pio_sequencer_if bus ();

  pio_sequencer #(.PERIOD_W(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef PIO_SEQ_IRQ_EN
    .irq     (irq),
`endif
    .bus     (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model_pat [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Every strobe must match the head of the scoreboard; every other cycle the master bus must be idle.
  always @(negedge clk) begin
    if (bus.m_chipselect) begin
      check_output("strobe_write_n", {31'b0, bus.m_write_n}, 32'd0);
      check_output("strobe_addr", {30'b0, bus.m_address}, 32'd0);
      check_output("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_output("strobe_data", bus.m_writedata, mon_e.data);
        check_output("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      check_output("idle_bus", bus.m_writedata | {29'b0, ~bus.m_write_n, bus.m_address}, 32'd0);
    end
  end

  task automatic apply_stimulus(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.s_address    = addr;
    bus.s_writedata  = data;
    bus.s_chipselect = 1'b1;
    bus.s_write_n    = 1'b0;
    @(negedge clk);
    bus.s_chipselect = 1'b0;
    bus.s_write_n    = 1'b1;
  endtask

  task automatic csr_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.s_address    = addr;
    bus.s_chipselect = 1'b1;
    bus.s_write_n    = 1'b1;
    #1;
    data = bus.s_readdata;
    bus.s_chipselect = 1'b0;
  endtask

  task automatic check_csr(input string tag, input logic [3:0] addr, input logic [31:0] expected);
    logic [31:0] rd;
    csr_read(addr, rd);
    check_output(tag, rd, expected);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++)
      @(negedge clk);
    check_output(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++)
      check_csr($sformatf("%s_addr%0d", tag, a), 4'(a), 32'd0);
  endtask

  // Programs PERIOD/LENGTH, writes CTRL and queues n expected strobes from the accepting edge onward.
  task automatic start_run(input logic [31:0] ctrl_val, input int p, input int l, input int n,
                           output int k);
    int ep;
    int el;
    apply_stimulus(4'd2, 32'(p));
    apply_stimulus(4'd3, 32'(l));
    ep = (p < 2) ? 2 : p;
    el = (l == 0) ? 1 : ((l > 8) ? 8 : l);
    @(negedge clk);
    bus.s_address    = 4'd0;
    bus.s_writedata  = ctrl_val;
    bus.s_chipselect = 1'b1;
    bus.s_write_n    = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{data: {24'b0, model_pat[i % el]}, cyc: k + i * ep});
    @(negedge clk);
    bus.s_chipselect = 1'b0;
    bus.s_write_n    = 1'b1;
  endtask

  task automatic write_pattern(input int idx, input logic [7:0] val);
    model_pat[idx] = val;
    apply_stimulus(4'(8 + idx), {24'b0, val});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          k;
    logic [31:0] rd;

    reset_n          = 1'b0;
    bus.s_address    = '0;
    bus.s_chipselect = 1'b0;
    bus.s_write_n    = 1'b1;
    bus.s_writedata  = '0;
    for (int i = 0; i < 8; i++) model_pat[i] = 8'h00;

    wait_cycles(2);
    check_output("reset_m_cs", {31'b0, bus.m_chipselect}, 32'd0);
    check_output("reset_m_wn", {31'b0, bus.m_write_n}, 32'd1);
    check_all_zero("reset_csr");
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(2);

    $display("[TB] single pass, length 3, period 5");
    write_pattern(0, 8'h01);
    write_pattern(1, 8'h02);
    write_pattern(2, 8'h04);
    start_run(32'h1, 5, 3, 3, k);
    check_csr("run_busy", 4'd1, 32'h01);
    check_csr("period_rd", 4'd2, 32'd5);
    wait_drain("drain_pass3", 40);
    wait_cycles(8);
    check_csr("pass3_status", 4'd1, 32'h22);
    apply_stimulus(4'd1, 32'h2);
    check_csr("done_clear", 4'd1, 32'h20);

    $display("[TB] length clamps");
    write_pattern(3, 8'h08);
    write_pattern(4, 8'h10);
    write_pattern(5, 8'h20);
    write_pattern(6, 8'h40);
    write_pattern(7, 8'h80);
    start_run(32'h1, 2, 12, 8, k);
    check_csr("length_rd", 4'd3, 32'd12);
    wait_drain("drain_len12", 60);
    wait_cycles(6);
    check_csr("len12_status", 4'd1, 32'h72);
    start_run(32'h1, 5, 0, 1, k);
    check_csr("start_clears_done", 4'd1, 32'h01);
    wait_drain("drain_len0", 20);
    wait_cycles(8);
    check_csr("len0_status", 4'd1, 32'h02);

    $display("[TB] busy writes: ignored START, live PATTERN update");
    model_pat[3] = 8'hA5;
    start_run(32'h1, 4, 8, 8, k);
    apply_stimulus(4'd0, 32'h1);
    apply_stimulus(4'd11, 32'hA5);
    wait_drain("drain_live", 60);
    wait_cycles(6);
    check_csr("live_status", 4'd1, 32'h72);

    $display("[TB] loop with period 0 then STOP");
    start_run(32'h3, 0, 2, 6, k);
    while (cyc < k + 10) @(negedge clk);
    apply_stimulus(4'd0, 32'h6);
    wait_drain("drain_loop", 5);
    wait_cycles(10);
    check_csr("stop_status", 4'd1, 32'h10);
    apply_stimulus(4'd0, 32'h5);
    wait_cycles(10);
    check_csr("stop_start_status", 4'd1, 32'h10);

    $display("[TB] reset during WAIT");
    start_run(32'h1, 10, 3, 1, k);
    wait_cycles(3);
    reset_n = 1'b0;
    #1;
    check_output("rst_m_cs", {31'b0, bus.m_chipselect}, 32'd0);
    check_output("rst_m_wn", {31'b0, bus.m_write_n}, 32'd1);
    check_all_zero("rst_mid_csr");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) model_pat[i] = 8'h00;
    wait_cycles(30);
    check_output("rst_no_pending", 32'(exp_q.size()), 32'd0);
    start_run(32'h1, 0, 0, 1, k);
    wait_drain("drain_after_rst", 10);
    wait_cycles(4);
    check_csr("after_rst_status", 4'd1, 32'h02);

`ifdef PIO_SEQ_IRQ_EN
    $display("[TB] irq");
    start_run(32'h9, 2, 1, 1, k);
    wait_cycles(2);
    check_output("irq_before", {31'b0, irq}, 32'd0);
    wait_cycles(1);
    check_output("irq_rise", {31'b0, irq}, 32'd1);
    apply_stimulus(4'd1, 32'h2);
    wait_cycles(2);
    check_output("irq_fall", {31'b0, irq}, 32'd0);
    check_csr("ien_rd", 4'd0, 32'h8);
`else
    $display("[TB] IEN absent");
    apply_stimulus(4'd0, 32'h8);
    check_csr("ien_absent", 4'd0, 32'h0);
    apply_stimulus(4'd0, 32'hA);
    check_csr("loop_only", 4'd0, 32'h2);
    apply_stimulus(4'd0, 32'h0);
`endif

    wait_cycles(4);
    check_output("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
